// File: rtl/addr_seq_gen_pkg.sv
// Shared control definitions for the address sequencer and the blocks that
// reuse its index-to-base mapping.
package addr_seq_gen_pkg;

    // Default geometry of the control-path address map.
    localparam int DEF_ADDR_W = 14;
    localparam int DEF_BANK_W = 2;
    localparam int BANK_SHIFT = DEF_ADDR_W - DEF_BANK_W;

    // Sequencer state encoding, kept as plain constants so older blocks that
    // decode the state bits keep working.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    // Indices below the bank count select a whole bank; the rest name registers.
    function automatic logic is_bank_idx(input int unsigned idx, input int unsigned num_banks);
        return idx < num_banks;
    endfunction

endpackage

// File: rtl/addr_seq_gen_base_map.sv
// Combinational index-to-base mapping: bank indices map to the bank's base
// address, register indices map straight onto the low address bits.
module addr_base_map
    import addr_seq_gen_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int BANK_W    = 2,
    parameter int IDX_W     = 4,
    parameter int NUM_BANKS = 4
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] base,
    output logic              is_bank
);

    localparam int SHIFT = ADDR_W - BANK_W;

    // Resolve the index to its base address and classify it.
    always_comb begin
        // NOTE: every output gets a value before any condition so no latch is inferred.
        is_bank = is_bank_idx(32'(idx), NUM_BANKS);
        base    = ADDR_W'(idx);
        if (is_bank) begin
            base = ADDR_W'(idx) << SHIFT;
        end
    end

endmodule

// File: rtl/addr_seq_gen.sv
// Address sequencer: accepts a burst command, resolves its base address and
// streams one address per accepted beat, then pulses done.
module addr_seq_gen
    import addr_seq_gen_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int BANK_W    = 2,
    parameter int IDX_W     = 4,
    parameter int NUM_BANKS = 4,
    parameter int LEN_W     = 12,
    parameter int STRIDE_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IDX_W-1:0]    cmd_index,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [STRIDE_W-1:0] cmd_stride,
    input  logic                cmd_wrap,
    input  logic                abort,
    output logic                addr_valid,
    input  logic                addr_ready,
    output logic [ADDR_W-1:0]   addr,
    output logic                addr_last,
    output logic                busy,
    output logic                done
);

    localparam int SHIFT = ADDR_W - BANK_W;

    logic [1:0]          state_q,  state_d;
    logic [LEN_W-1:0]    cnt_q,    cnt_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic                wrap_q,   wrap_d;

    logic [ADDR_W-1:0]   base;
    logic                base_is_bank;
    logic [ADDR_W-1:0]   sum;
    logic [ADDR_W-1:0]   next_addr;

    addr_base_map #(
        .ADDR_W    (ADDR_W),
        .BANK_W    (BANK_W),
        .IDX_W     (IDX_W),
        .NUM_BANKS (NUM_BANKS)
    ) u_base_map (
        .idx     (cmd_index),
        .base    (base),
        .is_bank (base_is_bank)
    );

    // Next beat address: wrap keeps the bank bits and lets the offset roll
    // over; otherwise the carry may run into the bank bits.
    always_comb begin
        sum       = addr_q + ADDR_W'(stride_q);
        next_addr = sum;
        if (wrap_q) begin
            next_addr = {addr_q[ADDR_W-1:SHIFT], sum[SHIFT-1:0]};
        end
    end

    // Sequencer control: command capture, beat stepping, abort and completion.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        wrap_d   = wrap_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = RUN;
                    addr_d  = base;
                    if (base_is_bank) begin
                        cnt_d    = cmd_len;
                        stride_d = cmd_stride;
                        wrap_d   = cmd_wrap;
                    end else begin
                        // A register is a single fixed address.
                        cnt_d    = '0;
                        stride_d = '0;
                        wrap_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    // Abort wins even over a beat accepted in the same cycle.
                    state_d = IDLE;
                end else if (addr_ready) begin
                    if (cnt_q == '0) begin
                        state_d = FIN;
                    end else begin
                        cnt_d  = cnt_q - LEN_W'(1);
                        addr_d = next_addr;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            wrap_q   <= wrap_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign addr_valid = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == FIN);
    assign addr_last  = (state_q == RUN) && (cnt_q == '0);
    assign addr       = addr_q;

endmodule
